cla_32: RTL and testbench
=========================

# cla_32

Two-level 32-bit carry-lookahead adder with registered outputs. It is the arithmetic core of the single-cycle RISC-V ALU. The ALU performs subtraction by inverting B and driving CIN=1 before this block, so the block itself only computes A + B + CIN. It also exports the bitwise generate (A&B) and propagate (A^B) vectors, which the ALU reuses as its AND and XOR results.

## Interface
- No parameters; width fixed at 32.
- CLK  input  1  system clock; all outputs update on its rising edge.
- RSTN  input  1  synchronous active-low reset, sampled on rising CLK.
- A  input  32  operand A.
- B  input  32  operand B, already conditioned by the caller.
- CIN  input  1  carry into bit 0.
- SUM  output  32  registered (A + B + CIN) mod 2^32.
- OF  output  1  registered two's-complement overflow: carry into bit 31 XOR carry out of bit 31.
- BAND  output  32  registered A & B.
- BXOR  output  32  registered A ^ B.

## Operation
- Bit level: g[i] = A[i]&B[i], p[i] = A[i]^B[i].
- Level 1: eight 4-bit lookahead blocks.
  - Each block computes its internal carries c[i+1] = g[i] | p[i]&c[i] in flattened two-level form (no ripple).
  - Each block also computes group generate G = g3|p3g2|p3p2g1|p3p2p1g0 and group propagate P = p3p2p1p0.
- Level 2: a lookahead unit takes the eight (G,P) pairs plus CIN.
  - It produces the block carry-ins C0 = CIN through C7 in flattened form.
  - It also produces the final carry C8, which is the carry out of bit 31.
- Sum: SUM[i] = p[i] ^ c[i].
- Overflow: OF = c31 ^ C8, where c31 is the carry into bit 31. OF is signed overflow, not unsigned carry out.
- BAND = g, BXOR = p, exposed unmodified.
- The carry chain must contain no ripple path longer than one 4-bit block. Inferring a behavioural "+" for SUM is not allowed.
- Unknown (X) inputs may propagate to the outputs. No X-masking is required.

## Timing
- The combinational core is fully evaluated within one cycle.
- All four outputs are captured in a single register stage on the rising CLK edge: latency 1 cycle, throughput 1 result per cycle.
- No handshake. Inputs are sampled on every rising edge.
- Reset:
  - If RSTN=0 at a rising edge, SUM, BAND and BXOR become 32'h0 and OF becomes 0 on that edge. Inputs are ignored.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid result appears on the edge after RSTN returns to 1.
- Boundary behaviour:
  - Wrap-around: A=32'hFFFFFFFF, B=0, CIN=1 gives SUM=0 and OF=0.
  - All-propagate case (A^B = all ones, CIN=1): the carry must pass through the level-2 unit within the same cycle.
- Inputs changing between edges have no effect on the outputs until the next edge.

## Test plan
- Reset:
  - Drive A=32'h12345678, B=32'h1, CIN=1 with RSTN=0 for 2 edges -> SUM=0, OF=0, BAND=0, BXOR=0.
  - Release RSTN -> one edge later SUM=32'h1234567A.
- Add without overflow: A=5, B=7, CIN=0 -> SUM=12, OF=0, BAND=32'h5, BXOR=32'h2.
- Signed overflow:
  - A=32'h7FFFFFFF, B=1, CIN=0 -> SUM=32'h80000000, OF=1.
  - A=32'h80000000, B=32'h80000000, CIN=0 -> SUM=0, OF=1.
- Subtraction as driven by the ALU:
  - A=10, B=~3 (32'hFFFFFFFC), CIN=1 -> SUM=7, OF=0.
  - A=3, B=~10, CIN=1 -> SUM=32'hFFFFFFF9, OF=0.
- Full carry propagation: A=32'hFFFFFFFF, B=0, CIN=1 -> SUM=0, OF=0, BXOR=32'hFFFFFFFF, BAND=0.
- Pipelining and randomised check:
  - Apply back-to-back vectors on consecutive cycles -> each result appears exactly one edge after its inputs.
  - Run 10k random A, B, CIN -> SUM, OF, BAND and BXOR all match the reference model.

Source files
------------

// File: rtl/cla_32.sv
// Two-level 32-bit carry-lookahead adder: eight 4-bit lookahead blocks feeding
// a flattened group-carry unit, with SUM/OF/BAND/BXOR captured in one register stage.

module cla_blk4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       ci,
  output logic [3:0] c,
  output logic       gg,
  output logic       gp
);
  // c[i] is the carry into bit i of this block; every term is a flat AND-OR
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp   = &p;
endmodule

module cla_32 (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        CIN,
  output logic [31:0] SUM,
  output logic        OF,
  output logic [31:0] BAND,
  output logic [31:0] BXOR
);
  localparam int NUM_BLK = 8;
  localparam int BLK_W   = 4;

  logic [NUM_BLK-1:0][BLK_W-1:0] g, p, c;
  logic [NUM_BLK-1:0]            grp_g, grp_p;
  logic [NUM_BLK:0]              blk_c;

  assign g = A & B;
  assign p = A ^ B;

  genvar k;
  generate
    for (k = 0; k < NUM_BLK; k++) begin : g_blk
      cla_blk4 u_blk (
        .g  (g[k]),
        .p  (p[k]),
        .ci (blk_c[k]),
        .c  (c[k]),
        .gg (grp_g[k]),
        .gp (grp_p[k])
      );
    end
  endgenerate

  // Each block carry is an independent sum of products over (G,P,CIN), so the
  // only ripple left is inside a single 4-bit block.
  always_comb begin
    logic term;
    blk_c = '0;
    blk_c[0] = CIN;
    for (int n = 1; n <= NUM_BLK; n++) begin
      term = CIN;
      for (int m = 0; m < n; m++) term = term & grp_p[m];
      blk_c[n] = term;
      for (int j = 0; j < n; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < n; m++) term = term & grp_p[m];
        blk_c[n] = blk_c[n] | term;
      end
    end
  end

  logic [31:0] sum_d;
  assign sum_d = p ^ c;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      SUM  <= '0;
      OF   <= 1'b0;
      BAND <= '0;
      BXOR <= '0;
    end else begin
      SUM  <= sum_d;
      OF   <= c[NUM_BLK-1][BLK_W-1] ^ blk_c[NUM_BLK];
      BAND <= g;
      BXOR <= p;
    end
  end
endmodule

// File: tb/tb_cla_32.sv
// Bench for cla_32: directed literal vectors plus randomized traffic checked every
// cycle against an arithmetic reference model.

module tb_cla_32;
  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] A, B;
  logic        CIN;
  logic [31:0] SUM, BAND, BXOR;
  logic        OF;

  int n_chk = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  cla_32 dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .A    (A),
    .B    (B),
    .CIN  (CIN),
    .SUM  (SUM),
    .OF   (OF),
    .BAND (BAND),
    .BXOR (BXOR)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference model: plain wide addition, sign-rule overflow.
  logic [32:0] m_w;
  logic [31:0] m_sum, m_and, m_xor;
  logic        m_of;
  always @(posedge CLK) begin
    if (RSTN !== 1'b1) begin
      m_sum = '0; m_and = '0; m_xor = '0; m_of = 1'b0;
    end else begin
      m_w   = {1'b0, A} + {1'b0, B} + {32'b0, CIN};
      m_sum = m_w[31:0];
      m_of  = (A[31] == B[31]) && (m_sum[31] != A[31]);
      m_and = A & B;
      m_xor = A ^ B;
    end
    #1;
    chk("model_sum",  SUM,  m_sum);
    chk("model_of",   32'(OF), 32'(m_of));
    chk("model_band", BAND, m_and);
    chk("model_bxor", BXOR, m_xor);
  end

  task automatic vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input logic [31:0] es, input logic eo,
                     input logic [31:0] ea, input logic [31:0] ex);
    @(negedge CLK);
    A = a; B = b; CIN = ci;
    @(posedge CLK);
    #2;
    chk({nm, "_sum"},  SUM,  es);
    chk({nm, "_of"},   32'(OF), 32'(eo));
    chk({nm, "_band"}, BAND, ea);
    chk({nm, "_bxor"}, BXOR, ex);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'h0;
      1: pick = 32'hFFFFFFFF;
      2: pick = 32'h7FFFFFFF;
      3: pick = 32'h80000000;
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    RSTN = 1'b0; A = 32'h12345678; B = 32'h1; CIN = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    chk("rst_sum",  SUM,  32'h0);
    chk("rst_of",   32'(OF), 32'h0);
    chk("rst_band", BAND, 32'h0);
    chk("rst_bxor", BXOR, 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    @(posedge CLK);
    #2;
    chk("first_sum", SUM, 32'h1234567A);

    // back-to-back directed vectors, one per cycle
    vec("add",   32'd5,        32'd7,        1'b0, 32'd12,       1'b0, 32'h5,        32'h2);
    vec("ovf_p", 32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 1'b1, 32'h1,        32'h7FFFFFFE);
    vec("ovf_n", 32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b1, 32'h80000000, 32'h0);
    vec("sub1",  32'd10,       32'hFFFFFFFC, 1'b1, 32'd7,        1'b0, 32'h8,        32'hFFFFFFF6);
    vec("sub2",  32'd3,        32'hFFFFFFF5, 1'b1, 32'hFFFFFFF9, 1'b0, 32'h1,        32'hFFFFFFF6);
    vec("wrap",  32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        32'hFFFFFFFF);
    vec("allp",  32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h0,        1'b0, 32'h0,        32'hFFFFFFFF);

    for (int i = 0; i < 10000; i++) begin
      @(negedge CLK);
      RSTN = (i == 5000) ? 1'b0 : 1'b1;
      A = pick(); B = pick(); CIN = 1'($urandom_range(0, 1));
    end
    @(negedge CLK);
    @(posedge CLK);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
